// File: rtl/logic_seq_64bit.sv
// Multi-cycle bitwise logic unit: XOR/OR/AND/XNOR applied one SLICE-bit
// slice per cycle, valid/ready request and response handshakes.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a request, in_ready=1
// COMPUTE | one slice of c written per cycle, low slice first
// DONE    | result held on c with out_valid=1 until out_ready
module logic_seq_64bit #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             busy
);

  localparam int NBEATS = WIDTH / SLICE;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_c;
  logic [SLICE-1:0] slice_a, slice_b, slice_r;

  function automatic logic [SLICE-1:0] bit_op(input logic [SLICE-1:0] x,
                                              input logic [SLICE-1:0] y,
                                              input logic [1:0]       sel);
    logic [SLICE-1:0] r;
    case (sel)
      2'b00:   r = x ^ y;
      2'b01:   r = x | y;
      2'b10:   r = x & y;
      default: r = ~(x ^ y);
    endcase
    return r;
  endfunction

  // Current slice of the latched operands and its result.
  always_comb begin
    slice_a = a_q[SLICE*int'(cnt_q) +: SLICE];
    slice_b = b_q[SLICE*int'(cnt_q) +: SLICE];
    slice_r = bit_op(slice_a, slice_b, op_q);
  end

  // Next-state, operand capture, per-beat slice write and handshake logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    in_ready_c  = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        c_d[SLICE*int'(cnt_q) +: SLICE] = slice_r;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BEAT) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        // A new request can ride the same edge that retires the result.
        in_ready_c = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            op_d    = op;
            cnt_d   = '0;
            state_d = COMPUTE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
    end
  end

  // in_ready is masked while reset is asserted since the state reads IDLE then.
  assign in_ready  = in_ready_c & rst_n;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_seq_64bit.sv
// Bench for logic_seq_64bit: whole-word behavioural model with per-cycle
// compare, directed literal cases and a randomized handshake phase.
module tb_logic_seq_64bit;

  localparam int NB = 4;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic [1:0]  op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // model: beats left on the op in flight, result held, values
  int          m_left = 0;
  bit          m_has  = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_out  = '0;

  logic_seq_64bit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .c        (c),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] f_model(input logic [63:0] x, input logic [63:0] y,
                                          input logic [1:0] s);
    case (s)
      2'd0:    return x ^ y;
      2'd1:    return x | y;
      2'd2:    return x & y;
      default: return ~(x ^ y);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit model_in_ready();
    return rst_n && (m_left == 0) && (!m_has || out_ready);
  endfunction

  task automatic model_clear();
    m_left = 0;
    m_has  = 0;
  endtask

  // Called just after the active edge with the inputs that edge saw.
  task automatic model_step(input bit acc, input bit ordy, input logic [63:0] aa,
                            input logic [63:0] bb, input logic [1:0] oo);
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (m_has && ordy) m_has = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_has = 1;
        m_out = m_pend;
      end
    end
    if (acc) begin
      m_pend = f_model(aa, bb, oo);
      m_left = NB;
    end
  endtask

  // One clock: compare outputs against the model, cross the edge, advance model.
  task automatic cyc(output bit acc);
    bit          ordy;
    logic [63:0] aa, bb;
    logic [1:0]  oo;
    #1;
    chk("in_ready", 64'(in_ready), 64'(model_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_has));
    chk("busy", 64'(busy), 64'((m_left > 0) || m_has));
    if (m_has) chk("c", c, m_out);
    acc  = in_valid && model_in_ready();
    ordy = out_ready;
    aa   = a;
    bb   = b;
    oo   = op;
    @(posedge clk);
    model_step(acc, ordy, aa, bb, oo);
    @(negedge clk);
  endtask

  task automatic scramble();
    a  = {$urandom, $urandom};
    b  = {$urandom, $urandom};
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic issue(input logic [63:0] aa, input logic [63:0] bb, input logic [1:0] oo);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    a = aa; b = bb; op = oo;
    while (!acc && n < 50) begin
      cyc(acc);
      n++;
    end
    chk("accepted", 64'(acc), 64'(1));
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_result(output int lat);
    bit dummy;
    lat = 0;
    while (!out_valid && lat < 50) begin
      cyc(dummy);
      lat++;
    end
    chk("result_arrives", 64'(out_valid), 64'(1));
  endtask

  task automatic run_op(input string name, input logic [63:0] aa, input logic [63:0] bb,
                        input logic [1:0] oo, input logic [63:0] exp);
    int lat;
    bit dummy;
    issue(aa, bb, oo);
    wait_result(lat);
    chk({name, "_latency"}, 64'(lat), 64'(NB));
    chk(name, c, exp);
    cyc(dummy);
  endtask

  initial begin
    bit          acc;
    logic [63:0] c_hold;
    int          acc_cyc[$];
    int          t;
    int          lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_c", c, 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(acc);

    run_op("xor", 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd0, 64'hF0F0_0F0F_5555_5555);
    run_op("or",  64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd1, 64'hFFFF_0F0F_FFFF_5555);
    run_op("and", 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd2, 64'h0F0F_0000_AAAA_0000);
    run_op("xnor",64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd3, 64'h0F0F_F0F0_AAAA_AAAA);

    // backpressure with a second request waiting
    out_ready = 1'b0;
    issue(64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd0);
    wait_result(lat);
    c_hold = c;
    chk("bp_first", c, 64'hF0F0_0F0F_5555_5555);
    in_valid = 1'b1;
    a = 64'hFFFF_0000_AAAA_5555; b = 64'h0F0F_0F0F_FFFF_0000; op = 2'd1;
    for (int i = 0; i < 10; i++) begin
      cyc(acc);
      chk("bp_no_accept", 64'(acc), 64'(0));
      chk("bp_c_stable", c, c_hold);
      chk("bp_valid_held", 64'(out_valid), 64'(1));
    end
    out_ready = 1'b1;
    cyc(acc);
    chk("bp_same_edge_accept", 64'(acc), 64'(1));
    in_valid = 1'b0;
    scramble();
    wait_result(lat);
    chk("bp_second", c, 64'hFFFF_0F0F_FFFF_5555);
    cyc(acc);

    // back-to-back, operands scrambled every cycle
    in_valid = 1'b1;
    scramble();
    t = 0;
    while (acc_cyc.size() < 3 && t < 60) begin
      cyc(acc);
      if (acc) acc_cyc.push_back(t);
      t++;
      scramble();
    end
    in_valid = 1'b0;
    chk("b2b_count", 64'(acc_cyc.size()), 64'(3));
    if (acc_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(NB + 1));
      chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(NB + 1));
    end
    for (int i = 0; i < NB + 3; i++) cyc(acc);

    // reset during beat 2
    issue(64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd2);
    cyc(acc);
    cyc(acc);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_c", c, 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    cyc(acc);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    run_op("post_rst_xnor", 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_FFFF_0000, 2'd3,
           64'h0F0F_F0F0_AAAA_AAAA);

    run_op("edge_ones_xor", ONES, ONES, 2'd0, 64'h0);
    run_op("edge_zero_xnor", 64'h0, 64'h0, 2'd3, ONES);

    // randomized handshake traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      scramble();
      cyc(acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
